// File: rtl/brp_fetch_redirect.sv
// Next-PC generator and fetch-redirect controller sitting in front of the branch predictor.
// Optional per-class redirect counters are enabled with the BRP_REDIRECT_STATS_EN macro.

package rv32i_brp_pkg;
    typedef struct packed {
        logic        prediction;
        logic        predicted;
        logic        jal;
        logic [31:0] brp_target;
        logic        mp_valid;
        logic        mispredicted;
        logic [31:0] brp_alt;
    } rv32i_brp_word;
endpackage

// state | meaning
// RUN   | normal fetch; redirects applied directly when fetch_ready
// HOLD  | fetch stalled with a redirect pending; pc_out frozen
// DRAIN | pc_valid held low for FLUSH_CYCLES after a mispredict/JALR redirect
module brp_fetch_redirect
    import rv32i_brp_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h4000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_ready,
    input  rv32i_brp_word brp_if,
    input  rv32i_brp_word brp_ex,
    input  logic          jalr_valid,
    input  logic [31:0]   jalr_target,
    output logic [31:0]   pc_out,
    output logic          pc_valid,
    output logic          flush
`ifdef BRP_REDIRECT_STATS_EN
    ,
    output logic [31:0]   stat_mispredict,
    output logic [31:0]   stat_jalr,
    output logic [31:0]   stat_taken
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Redirect class encoding doubles as priority: larger value wins.
    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_TK   = 2'd1;
    localparam logic [1:0] CLS_JR   = 2'd2;
    localparam logic [1:0] CLS_MP   = 2'd3;

    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_CYCLES);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic        r_flush;
    logic [1:0]  r_pend_cls;
    logic [31:0] r_pend_tgt;
    logic [2:0]  r_cnt;

    logic        w_mp;
    logic        w_jr;
    logic        w_tk;
    logic [31:0] w_pc_seq;
    logic [1:0]  w_src_cls;
    logic [31:0] w_src_raw;
    logic [31:0] w_src_tgt;
    logic        w_src_flush;
    logic        w_pend_take;
    logic [1:0]  w_eff_cls;
    logic [31:0] w_eff_tgt;
    logic        w_eff_flush;
    logic        w_unused;

    assign w_mp     = brp_ex.mp_valid && brp_ex.mispredicted;
    assign w_jr     = jalr_valid;
    assign w_tk     = brp_if.prediction && (brp_if.predicted || brp_if.jal);
    assign w_pc_seq = r_pc + 32'd4;

    always_comb begin
        w_src_cls = CLS_NONE;
        w_src_raw = w_pc_seq;
        if (w_mp) begin
            w_src_cls = CLS_MP;
            w_src_raw = brp_ex.brp_alt;
        end else if (w_jr) begin
            w_src_cls = CLS_JR;
            w_src_raw = jalr_target;
        end else if (w_tk) begin
            w_src_cls = CLS_TK;
            w_src_raw = brp_if.brp_target;
        end
    end

    assign w_src_tgt   = {w_src_raw[31:2], 2'b00};
    assign w_src_flush = (w_src_cls == CLS_MP) || (w_src_cls == CLS_JR);

    // In HOLD a new source replaces the pending one only at equal or higher priority.
    assign w_pend_take = (w_src_cls != CLS_NONE) && (w_src_cls >= r_pend_cls);
    assign w_eff_cls   = w_pend_take ? w_src_cls : r_pend_cls;
    assign w_eff_tgt   = w_pend_take ? w_src_tgt : r_pend_tgt;
    assign w_eff_flush = (w_eff_cls == CLS_MP) || (w_eff_cls == CLS_JR);

    // Record fields this block never looks at on each side.
    assign w_unused = ^{brp_ex.prediction, brp_ex.predicted, brp_ex.jal, brp_ex.brp_target,
                        brp_if.mp_valid, brp_if.mispredicted, brp_if.brp_alt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_pend_cls <= CLS_NONE;
            r_pend_tgt <= '0;
            r_cnt      <= '0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_pc_valid <= 1'b1;
                    if (fetch_ready) begin
                        r_pc <= w_src_tgt;
                        if (w_src_flush) begin
                            r_flush    <= 1'b1;
                            r_pc_valid <= 1'b0;
                            r_cnt      <= DRAIN_LOAD;
                            r_state    <= ST_DRAIN;
                        end
                    end else if (w_src_cls != CLS_NONE) begin
                        r_pend_cls <= w_src_cls;
                        r_pend_tgt <= w_src_tgt;
                        r_flush    <= w_src_flush;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_flush <= w_pend_take && w_src_flush;
                    if (fetch_ready) begin
                        r_pc       <= w_eff_tgt;
                        r_pend_cls <= CLS_NONE;
                        r_pend_tgt <= '0;
                        if (w_eff_flush) begin
                            r_pc_valid <= 1'b0;
                            r_cnt      <= DRAIN_LOAD;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (w_pend_take) begin
                        r_pend_cls <= w_src_cls;
                        r_pend_tgt <= w_src_tgt;
                    end
                end
                ST_DRAIN: begin
                    if (w_mp) begin
                        r_flush <= 1'b1;
                        r_cnt   <= DRAIN_LOAD;
                        if (fetch_ready) begin
                            r_pc <= w_src_tgt;
                        end else begin
                            r_pend_cls <= CLS_MP;
                            r_pend_tgt <= w_src_tgt;
                            r_state    <= ST_HOLD;
                        end
                    end else begin
                        if (fetch_ready) begin
                            r_pc <= w_pc_seq;
                        end
                        if (r_cnt == 3'd1) begin
                            r_pc_valid <= 1'b1;
                            r_state    <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc_out   = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;

`ifdef BRP_REDIRECT_STATS_EN
    logic [1:0]  w_apply_cls;
    logic [31:0] r_stat_mp;
    logic [31:0] r_stat_jr;
    logic [31:0] r_stat_tk;

    // Class of the redirect that actually lands in pc_out this cycle.
    always_comb begin
        w_apply_cls = CLS_NONE;
        if (fetch_ready) begin
            case (r_state)
                ST_RUN:   w_apply_cls = w_src_cls;
                ST_HOLD:  w_apply_cls = w_eff_cls;
                ST_DRAIN: w_apply_cls = w_mp ? CLS_MP : CLS_NONE;
                default:  w_apply_cls = CLS_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_mp <= '0;
            r_stat_jr <= '0;
            r_stat_tk <= '0;
        end else begin
            if (w_apply_cls == CLS_MP && r_stat_mp != 32'hFFFF_FFFF) r_stat_mp <= r_stat_mp + 32'd1;
            if (w_apply_cls == CLS_JR && r_stat_jr != 32'hFFFF_FFFF) r_stat_jr <= r_stat_jr + 32'd1;
            if (w_apply_cls == CLS_TK && r_stat_tk != 32'hFFFF_FFFF) r_stat_tk <= r_stat_tk + 32'd1;
        end
    end

    assign stat_mispredict = r_stat_mp;
    assign stat_jalr       = r_stat_jr;
    assign stat_taken      = r_stat_tk;
`endif

endmodule

// File: doc/brp_fetch_redirect.md
Name: brp_fetch_redirect

Overview:
- Next-PC generator and fetch-redirect controller, directly upstream of the branch predictor.
- Produces the IF-stage PC that the predictor indexes.
- Consumes the predictor's IF-side prediction and the EX-side resolution record.
- Steers fetch to:
  - the sequential PC,
  - a predicted-taken target,
  - a JALR target, or
  - the alternate PC after a mispredict.
- Holds redirects pending across fetch stalls and issues pipeline flushes.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset.
- FLUSH_CYCLES, 2, number of cycles pc_valid is suppressed after a mispredict or JALR redirect (range 1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fetch_ready  in  1  I-side accepts pc_out this cycle; low means stall.
- brp_if  in  rv32i_brp_word  prediction record for the instruction fetched last cycle.
- brp_ex  in  rv32i_brp_word  resolved record from EX; mp_valid qualifies mispredicted and brp_alt.
- jalr_valid  in  1  JALR resolved in EX this cycle.
- jalr_target  in  32  JALR target.
- pc_out  out  32  current fetch PC.
- pc_valid  out  1  pc_out is a real fetch; low during flush drain.
- flush  out  1  one-cycle pulse that kills IF/ID and ID/EX contents.

Behaviour:
- Reset (async, active-high):
  - pc_out=RESET_PC, pc_valid=0, flush=0, state=RUN, pending=0, drain counter=0.
  - pc_valid rises the first cycle after rst deasserts.
- Redirect sources, priority high to low (evaluated each cycle):
  1. Mispredict: brp_ex.mp_valid && brp_ex.mispredicted; target brp_ex.brp_alt.
  2. JALR: jalr_valid; target jalr_target.
  3. Predicted taken: brp_if.prediction && (brp_if.predicted || jal); target brp_if.brp_target.
  4. Sequential: pc_out+4, wraps modulo 2^32.
- All targets have bits [1:0] forced to 0 before use.
- States:
  - RUN: if fetch_ready, pc_out <= selected next PC on the next edge. If fetch_ready=0 and a source 1–3 fires, capture it in the pending register (target and class), go to HOLD, pc_out unchanged.
  - HOLD: pc_out frozen. A new higher-or-equal-priority source overwrites pending; a lower one is dropped. When fetch_ready=1, pc_out <= pending target, pending=0. Then go to DRAIN if the pending class is mispredict/JALR, else RUN.
  - DRAIN: pc_valid=0 for exactly FLUSH_CYCLES cycles (counter), pc_out advances normally by +4 only when fetch_ready, then RUN. A mispredict during DRAIN restarts the counter and redirects.
- flush:
  - Registered; high for exactly one cycle, the cycle after a mispredict or JALR is captured (RUN or HOLD).
  - Predicted-taken redirects never flush.
  - Two captures in consecutive cycles give two pulses.
- A mispredict in the same cycle as a predicted-taken brp_if: mispredict wins; the brp_if redirect is discarded.
- Mispredict and JALR together: the mispredict target is used; one flush pulse only.
- Latency: a source visible at edge N is reflected in pc_out after edge N when fetch_ready=1.
- rst asserted mid-HOLD/DRAIN: immediate return to reset values; pending is lost.

Optional Feature:
- Macro BRP_REDIRECT_STATS_EN.
- With the macro: adds outputs stat_mispredict, stat_jalr, stat_taken (each 32-bit), all cleared on rst.
  - Each increments once per redirect applied to pc_out of that class.
  - Saturating at 32'hFFFF_FFFF.
  - Dropped and overwritten pending redirects are not counted.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch_ready=1 for 3 cycles:
  - pc_out = 4000_0000, 4000_0004, 4000_0008, 4000_000C.
  - pc_valid=0 in reset, then 1; flush never asserted.
- Predicted taken: brp_if prediction=1, predicted=1, brp_target=4000_0100 at pc 4000_0008:
  - next pc_out=4000_0100, flush=0, pc_valid stays 1.
- Mispredict: brp_ex mp_valid=1, mispredicted=1, brp_alt=4000_0042 with fetch_ready=1:
  - pc_out=4000_0040 (bits [1:0] cleared), flush high one cycle.
  - pc_valid=0 for 2 cycles, then 1.
- Stall then fire:
  - fetch_ready=0, jalr_valid=1, target=4000_0200; next cycle mispredict with brp_alt=4000_0300 while still stalled.
  - Release after 3 cycles: pc_out=4000_0300; exactly two flush pulses; pc_out frozen throughout HOLD.
- Wrap: force pc_out=FFFF_FFFC, sequential fetch → pc_out=0000_0000.
- Reset during DRAIN (rst high mid-cycle, async):
  - pc_out=RESET_PC immediately, pc_valid=0, flush=0.
  - With BRP_REDIRECT_STATS_EN, all stat counters read 0.
